// File: rtl/pc_select_unit.sv
// pc_select_unit: fetch-PC generator for the pipelined Y86-64 core.
// Holds the predicted-PC register, picks the fetch PC each cycle and recovers
// from jXX mispredicts (M stage) and ret (W stage).
// Optional return-address stack: define PC_SELECT_RAS_EN to enable it.
module pc_select_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_stall_i,
    input  logic [3:0]        f_icode_i,
    input  logic [ADDR_W-1:0] f_valC_i,
    input  logic [ADDR_W-1:0] f_valP_i,
    input  logic [3:0]        m_icode_i,
    input  logic              m_cnd_i,
    input  logic [ADDR_W-1:0] m_valA_i,
    input  logic [3:0]        w_icode_i,
    input  logic [ADDR_W-1:0] w_valM_i,
    input  logic [ADDR_W-1:0] w_pred_pc_i,
    output logic [ADDR_W-1:0] f_pc_o,
    output logic [ADDR_W-1:0] pred_pc_o,
    output logic [ADDR_W-1:0] ret_pred_o,
    output logic              ret_redirect_o,
    output logic              ras_underflow_o
);

    localparam logic [3:0] I_HALT = 4'h0;
    localparam logic [3:0] I_JXX  = 4'h7;
    localparam logic [3:0] I_CALL = 4'h8;
    localparam logic [3:0] I_RET  = 4'h9;

    logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
    logic [ADDR_W-1:0] f_pc_c;
    logic [ADDR_W-1:0] ret_pred_c;
    logic              ret_redirect_c;
    logic              mispredict_c;

    // Not-taken jXX reaching M means the always-taken guess was wrong
    assign mispredict_c = (m_icode_i == I_JXX) && !m_cnd_i;

    // Fetch-PC selection: mispredict recovery beats ret recovery beats prediction
    always_comb begin
        f_pc_c = pred_pc_q;
        if (mispredict_c) begin
            f_pc_c = m_valA_i;
        end else if (ret_redirect_c) begin
            f_pc_c = w_valM_i;
        end
    end

    // Next predicted PC from the instruction fetched this cycle
    always_comb begin
        pred_pc_d = f_valP_i;
        case (f_icode_i)
            I_JXX, I_CALL: pred_pc_d = f_valC_i;
            I_RET:         pred_pc_d = ret_pred_c;
            I_HALT:        pred_pc_d = f_pc_c;
            default:       pred_pc_d = f_valP_i;
        endcase
    end

    // Predicted-PC register, frozen while fetch is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_pc_q <= RESET_PC;
        end else if (!f_stall_i) begin
            pred_pc_q <= pred_pc_d;
        end
    end

`ifdef PC_SELECT_RAS_EN
    localparam int unsigned    PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned    CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_ptr_q, ras_ptr_d, ras_top_idx;
    logic [CNT_W-1:0]  ras_cnt_q, ras_cnt_d;
    logic              ras_underflow_q, ras_underflow_d;
    logic              ras_empty;
    logic              fetch_call, fetch_ret;

    assign fetch_call  = !f_stall_i && (f_icode_i == I_CALL);
    assign fetch_ret   = !f_stall_i && (f_icode_i == I_RET);
    assign ras_empty   = (ras_cnt_q == '0);
    assign ras_top_idx = ras_ptr_q - PTR_W'(1);

    // A correct RAS guess for the ret in W needs no redirect
    assign ret_redirect_c = (w_icode_i == I_RET) && (w_valM_i != w_pred_pc_i);
    assign ret_pred_c     = ras_empty ? f_valP_i : ras_q[ras_top_idx];

    // Stack pointer/occupancy update; a full stack wraps over its oldest entry
    always_comb begin
        ras_ptr_d       = ras_ptr_q;
        ras_cnt_d       = ras_cnt_q;
        ras_underflow_d = 1'b0;
        if (fetch_call) begin
            ras_ptr_d = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q != RAS_FULL) begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (fetch_ret) begin
            if (ras_empty) begin
                ras_underflow_d = 1'b1;
            end else begin
                ras_ptr_d = ras_top_idx;
                ras_cnt_d = ras_cnt_q - CNT_W'(1);
            end
        end
    end

    // RAS control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_q       <= '0;
            ras_cnt_q       <= '0;
            ras_underflow_q <= 1'b0;
        end else begin
            ras_ptr_q       <= ras_ptr_d;
            ras_cnt_q       <= ras_cnt_d;
            ras_underflow_q <= ras_underflow_d;
        end
    end

    // RAS storage; entries are only read while the occupancy says they are valid
    always_ff @(posedge clk) begin
        if (fetch_call) begin
            ras_q[ras_ptr_q] <= f_valP_i;
        end
    end

    assign ras_underflow_o = ras_underflow_q;
`else
    logic unused_ras_inputs;

    // Without a RAS every ret redirects once it reaches W
    assign ret_redirect_c    = (w_icode_i == I_RET);
    assign ret_pred_c        = f_valP_i;
    assign ras_underflow_o   = 1'b0;
    assign unused_ras_inputs = ^{w_pred_pc_i, RAS_DEPTH[0]};
`endif

    assign f_pc_o         = f_pc_c;
    assign pred_pc_o      = pred_pc_q;
    assign ret_pred_o     = ret_pred_c;
    assign ret_redirect_o = ret_redirect_c;

endmodule

// File: tb/tb_pc_select_unit.sv
// Testbench for pc_select_unit: directed table, hand-written corner sequences
// and random traffic checked against a queue-based reference model.
module tb_pc_select_unit;

    localparam int unsigned AW    = 64;
    localparam int unsigned DEPTH = 8;
`ifdef PC_SELECT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    typedef struct {
        bit          stall;
        logic [3:0]  fi;
        logic [63:0] vc;
        logic [63:0] vp;
        logic [3:0]  mi;
        bit          mc;
        logic [63:0] ma;
        logic [3:0]  wi;
        logic [63:0] wm;
        logic [63:0] wp;
    } in_t;

    typedef struct {
        in_t         in;
        logic [63:0] e_fpc;
        bit          e_redir;
        logic [63:0] e_pred;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          f_stall;
    logic [3:0]    f_icode;
    logic [AW-1:0] f_valC, f_valP;
    logic [3:0]    m_icode;
    logic          m_cnd;
    logic [AW-1:0] m_valA;
    logic [3:0]    w_icode;
    logic [AW-1:0] w_valM, w_pred_pc;
    logic [AW-1:0] f_pc, pred_pc, ret_pred;
    logic          ret_redirect, ras_underflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: predicted PC, RAS as a queue (back = top)
    logic [63:0] m_pred;
    logic [63:0] m_ras[$];
    bit          m_unf;

    pc_select_unit #(.ADDR_W(AW), .RESET_PC('0), .RAS_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f_stall_i      (f_stall),
        .f_icode_i      (f_icode),
        .f_valC_i       (f_valC),
        .f_valP_i       (f_valP),
        .m_icode_i      (m_icode),
        .m_cnd_i        (m_cnd),
        .m_valA_i       (m_valA),
        .w_icode_i      (w_icode),
        .w_valM_i       (w_valM),
        .w_pred_pc_i    (w_pred_pc),
        .f_pc_o         (f_pc),
        .pred_pc_o      (pred_pc),
        .ret_pred_o     (ret_pred),
        .ret_redirect_o (ret_redirect),
        .ras_underflow_o(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t mk_in(bit stall, logic [3:0] fi, logic [63:0] vc, logic [63:0] vp,
                                  logic [3:0] mi, bit mc, logic [63:0] ma,
                                  logic [3:0] wi, logic [63:0] wm, logic [63:0] wp);
        in_t r;
        r.stall = stall; r.fi = fi; r.vc = vc; r.vp = vp;
        r.mi = mi; r.mc = mc; r.ma = ma;
        r.wi = wi; r.wm = wm; r.wp = wp;
        return r;
    endfunction

    function automatic in_t nop_in();
        return mk_in(0, 4'h1, 64'h0, 64'h0, 4'h1, 1'b1, 64'h0, 4'h1, 64'h0, 64'h0);
    endfunction

    task automatic drive(input in_t v);
        f_stall   = v.stall;
        f_icode   = v.fi;
        f_valC    = v.vc;
        f_valP    = v.vp;
        m_icode   = v.mi;
        m_cnd     = v.mc;
        m_valA    = v.ma;
        w_icode   = v.wi;
        w_valM    = v.wm;
        w_pred_pc = v.wp;
    endtask

    // One clock: check combinational outputs, advance the model, check registers
    task automatic cycle(input in_t v, output logic [63:0] fpc, output logic redir,
                         output logic [63:0] rp);
        bit          mis, e_redir;
        logic [63:0] e_fpc, e_rp;
        drive(v);
        #1;
        mis     = (v.mi == 4'h7) && !v.mc;
        e_redir = (v.wi == 4'h9) && (!RAS || (v.wm != v.wp));
        e_fpc   = mis ? v.ma : (e_redir ? v.wm : m_pred);
        e_rp    = (RAS && m_ras.size() > 0) ? m_ras[$] : v.vp;
        check("f_pc", f_pc, e_fpc);
        check("ret_redirect", 64'(ret_redirect), 64'(e_redir));
        check("ret_pred", ret_pred, e_rp);
        fpc   = f_pc;
        redir = ret_redirect;
        rp    = ret_pred;
        @(posedge clk);
        #1;
        if (!v.stall) begin
            case (v.fi)
                4'h7, 4'h8: m_pred = v.vc;
                4'h9:       m_pred = e_rp;
                4'h0:       m_pred = e_fpc;
                default:    m_pred = v.vp;
            endcase
            m_unf = RAS && (v.fi == 4'h9) && (m_ras.size() == 0);
            if (RAS && v.fi == 4'h8) begin
                m_ras.push_back(v.vp);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (RAS && v.fi == 4'h9 && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end else begin
            m_unf = 1'b0;
        end
        check("pred_pc", pred_pc, m_pred);
        check("ras_underflow", 64'(ras_underflow), 64'(m_unf));
    endtask

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    vec_t        tab[11];
    logic [63:0] fpc, rp, pre;
    logic        rd;
    in_t         v;

    initial begin
        // Directed vectors starting from pred_pc = 0 after reset
        tab[0]  = '{mk_in(0, 4'h6, 64'h55,  64'h0A,  4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h0,   0, 64'h0A};
        tab[1]  = '{mk_in(0, 4'h7, 64'h100, 64'h13,  4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h0A,  0, 64'h100};
        tab[2]  = '{mk_in(1, 4'h8, 64'h200, 64'h109, 4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h100, 0, 64'h100};
        tab[3]  = '{mk_in(1, 4'h8, 64'h200, 64'h109, 4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h100, 0, 64'h100};
        tab[4]  = '{mk_in(1, 4'h8, 64'h200, 64'h109, 4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h100, 0, 64'h100};
        tab[5]  = '{mk_in(0, 4'h1, 64'h0,   64'h2B,  4'h7, 0, 64'h2A, 4'h9, 64'h80, 64'h70), 64'h2A,  1, 64'h2B};
        tab[6]  = '{mk_in(0, 4'h2, 64'h0,   64'h82,  4'h1, 1, 64'h0,  4'h9, 64'h80, 64'h70), 64'h80,  1, 64'h82};
        tab[7]  = '{mk_in(0, 4'h0, 64'h0,   64'h83,  4'h7, 1, 64'h99, 4'h1, 64'h0,  64'h0),  64'h82,  0, 64'h82};
        tab[8]  = '{mk_in(0, 4'h0, 64'h0,   64'h31,  4'h7, 0, 64'h30, 4'h1, 64'h0,  64'h0),  64'h30,  0, 64'h30};
        tab[9]  = '{mk_in(0, 4'hB, 64'h0,   64'h32,  4'h1, 1, 64'h0,  4'h1, 64'h0,  64'h0),  64'h30,  0, 64'h32};
        tab[10] = '{mk_in(1, 4'h3, 64'h0,   64'h3C,  4'h7, 0, 64'h44, 4'h1, 64'h0,  64'h0),  64'h44,  0, 64'h32};

        // Reset
        rst_n = 1'b0;
        drive(nop_in());
        m_pred = 64'h0;
        m_unf  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pred_pc", pred_pc, 64'h0);
        check("reset_f_pc", f_pc, 64'h0);
        check("reset_underflow", 64'(ras_underflow), 64'h0);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            cycle(tab[i].in, fpc, rd, rp);
            check($sformatf("tab%0d_f_pc", i), fpc, tab[i].e_fpc);
            check($sformatf("tab%0d_redirect", i), 64'(rd), 64'(tab[i].e_redir));
            check($sformatf("tab%0d_pred_pc", i), pred_pc, tab[i].e_pred);
        end

        // Asynchronous reset mid-run from pred_pc = 0x40
        cycle(mk_in(0, 4'h7, 64'h40, 64'h5, 4'h1, 1, 64'h0, 4'h1, 64'h0, 64'h0), fpc, rd, rp);
        check("pre_reset_pred_pc", pred_pc, 64'h40);
        drive(nop_in());
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_pred_pc", pred_pc, 64'h0);
        check("async_reset_f_pc", f_pc, 64'h0);
        m_pred = 64'h0;
        m_unf  = 1'b0;
        m_ras.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Nine calls then nine rets: RAS overflow and underflow
        for (int k = 1; k <= 9; k++) begin
            cycle(mk_in(0, 4'h8, 64'h1000 + 64'(k), 64'h10 * 64'(k), 4'h1, 1, 64'h0, 4'h1, 64'h0, 64'h0),
                  fpc, rd, rp);
        end
        for (int k = 1; k <= 9; k++) begin
            cycle(mk_in(0, 4'h9, 64'h0, 64'h500 + 64'(k), 4'h1, 1, 64'h0, 4'h1, 64'h0, 64'h0),
                  fpc, rd, rp);
`ifdef PC_SELECT_RAS_EN
            if (k <= 8) check($sformatf("ras_pop%0d", k), rp, 64'hA0 - 64'h10 * 64'(k));
            else        check("ras_pop_empty", rp, 64'h509);
`else
            check($sformatf("ret_pred_fallthru%0d", k), rp, 64'h500 + 64'(k));
`endif
        end
`ifdef PC_SELECT_RAS_EN
        check("underflow_pulse", 64'(ras_underflow), 64'h1);
`endif
        cycle(nop_in(), fpc, rd, rp);
        check("underflow_cleared", 64'(ras_underflow), 64'h0);

        // Ret in W with a matching and a wrong RAS prediction
        pre = pred_pc;
        cycle(mk_in(0, 4'h1, 64'h0, 64'h600, 4'h1, 1, 64'h0, 4'h9, 64'h80, 64'h80), fpc, rd, rp);
`ifdef PC_SELECT_RAS_EN
        check("ret_match_redirect", 64'(rd), 64'h0);
        check("ret_match_f_pc", fpc, pre);
`else
        check("ret_noras_redirect", 64'(rd), 64'h1);
        check("ret_noras_f_pc", fpc, 64'h80);
`endif
        cycle(mk_in(0, 4'h1, 64'h0, 64'h610, 4'h1, 1, 64'h0, 4'h9, 64'h80, 64'h70), fpc, rd, rp);
        check("ret_miss_redirect", 64'(rd), 64'h1);
        check("ret_miss_f_pc", fpc, 64'h80);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            v.stall = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 9))
                0, 1:    v.fi = 4'h8;
                2, 3:    v.fi = 4'h9;
                4:       v.fi = 4'h7;
                5:       v.fi = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'h1;
                default: v.fi = 4'($urandom_range(1, 11));
            endcase
            v.vc = rnd64();
            v.vp = rnd64();
            v.mi = ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 11));
            v.mc = 1'($urandom);
            v.ma = rnd64();
            v.wi = ($urandom_range(0, 2) == 0) ? 4'h9 : 4'($urandom_range(0, 11));
            v.wm = rnd64();
            v.wp = ($urandom_range(0, 1) == 0) ? v.wm : rnd64();
            cycle(v, fpc, rd, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
